// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam logic [7:0]  BUBBLE_CTRL = 8'h00;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  // Enable/flush bundle driven to the pipeline registers and PC.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_out_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID-stage reader and the EX-stage load.
module pipeline_ctrl_hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  output logic                  lu_hazard_c
);

  // x0 is never a real dependency.
  assign lu_hazard_c = ex_is_load && (ex_rd != '0) &&
                       ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline with memory-wait watchdog.
// Optional performance counters enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_is_load_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  id_ex_en_o,
  output logic                  ex_mem_en_o,
  output logic                  mem_wb_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  mem_wb_flush_o,
  output logic                  mem_timeout_o,
  output logic [STATE_W-1:0]    state_o
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_events_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_out_t        ctrl, issue_ctrl, stall_ctrl;
  logic             lu_hazard;
  logic             mem_stall;
  logic             mem_done;

  pipeline_ctrl_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .rs1         (id_rs1_i),
    .rs2         (id_rs2_i),
    .uses_rs1    (id_uses_rs1_i),
    .uses_rs2    (id_uses_rs2_i),
    .ex_rd       (ex_rd_i),
    .ex_is_load  (ex_is_load_i),
    .lu_hazard_c (lu_hazard)
  );

  assign mem_stall = dmem_req_i && !dmem_ack_i;
  assign mem_done  = dmem_req_i && dmem_ack_i;

  // Control when memory is not holding the pipe: branch beats load-use.
  always_comb begin
    issue_ctrl           = ctrl_out_t'(BUBBLE_CTRL);
    issue_ctrl.pc_en     = 1'b1;
    issue_ctrl.if_id_en  = 1'b1;
    issue_ctrl.id_ex_en  = 1'b1;
    issue_ctrl.ex_mem_en = 1'b1;
    issue_ctrl.mem_wb_en = 1'b1;
    if (branch_taken_i) begin
      issue_ctrl.if_id_flush = 1'b1;
      issue_ctrl.id_ex_flush = 1'b1;
    end else if (lu_hazard) begin
      issue_ctrl.pc_en       = 1'b0;
      issue_ctrl.if_id_en    = 1'b0;
      issue_ctrl.id_ex_flush = 1'b1;
    end
  end

  // Freeze everything upstream of MEM and feed bubbles into WB.
  always_comb begin
    stall_ctrl              = ctrl_out_t'(BUBBLE_CTRL);
    stall_ctrl.mem_wb_en    = 1'b1;
    stall_ctrl.mem_wb_flush = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = ctrl_out_t'(BUBBLE_CTRL);
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl    = stall_ctrl;
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          ctrl = issue_ctrl;
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          ctrl    = issue_ctrl;
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          ctrl = stall_ctrl;
          if (cnt_q == CNT_MAX) begin
            state_d = ERROR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ERROR: begin
        ctrl = ctrl_out_t'(BUBBLE_CTRL);
      end
      default: begin
        ctrl    = ctrl_out_t'(BUBBLE_CTRL);
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_en_o        = ctrl.pc_en;
  assign if_id_en_o     = ctrl.if_id_en;
  assign id_ex_en_o     = ctrl.id_ex_en;
  assign ex_mem_en_o    = ctrl.ex_mem_en;
  assign mem_wb_en_o    = ctrl.mem_wb_en;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign mem_timeout_o  = (state_q == ERROR);
  assign state_o        = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_o <= '0;
      flush_events_o <= '0;
    end else begin
      if (!ctrl.pc_en && (state_q != ERROR)) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
      if (ctrl.if_id_flush) begin
        flush_events_o <= flush_events_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed plan scenarios then random traffic vs a reference model.
module tb_pipeline_ctrl;

  localparam int unsigned RW  = 5;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_is_load = 1'b0;
  logic          branch_taken = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
  logic [1:0]    state;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0]   stall_cycles, flush_events;
`endif

  pipeline_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_uses_rs1_i  (id_uses_rs1),
    .id_uses_rs2_i  (id_uses_rs2),
    .ex_rd_i        (ex_rd),
    .ex_is_load_i   (ex_is_load),
    .branch_taken_i (branch_taken),
    .dmem_req_i     (dmem_req),
    .dmem_ack_i     (dmem_ack),
    .pc_en_o        (pc_en),
    .if_id_en_o     (if_id_en),
    .id_ex_en_o     (id_ex_en),
    .ex_mem_en_o    (ex_mem_en),
    .mem_wb_en_o    (mem_wb_en),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .mem_wb_flush_o (mem_wb_flush),
    .mem_timeout_o  (mem_timeout),
    .state_o        (state)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ctl;   // {pc,if_id,id_ex,ex_mem,mem_wb,f_if_id,f_id_ex,f_mem_wb}
    logic        tmo;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
  } obs_t;

  typedef struct {
    bit          rst;   // 1 = reset released
    logic [RW-1:0] rs1, rs2, rd;
    bit          u1, u2, ld, br, req, ack;
  } stim_t;

  obs_t exp_q[$];
  int   tags_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: "mode" is running/waiting/dead; waits counts unacked wait cycles.
  int          m_mode = 0;
  int          m_waits = 0;
  logic [31:0] m_stalls = 0;
  logic [31:0] m_flushes = 0;
  int          tag = 0;

  task automatic step(input stim_t s);
    obs_t e;
    bit   hz, hold, pc, ifid, idex, exmem, memwb, fif, fid, fmw;
    @(posedge clk);
    #1;
    reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_is_load = s.ld;
    branch_taken = s.br; dmem_req = s.req; dmem_ack = s.ack;
    if (!s.rst) begin
      m_mode = 0; m_waits = 0; m_stalls = 0; m_flushes = 0;
    end
    hz = s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    hold = (m_mode == 0) ? (s.req && !s.ack) : !(s.req && s.ack);
    {pc, ifid, idex, exmem, memwb, fif, fid, fmw} = '0;
    if (m_mode != 2) begin
      if (hold) begin
        memwb = 1; fmw = 1;
      end else begin
        {pc, ifid, idex, exmem, memwb} = 5'b11111;
        if (s.br) begin
          fif = 1; fid = 1;
        end else if (hz) begin
          pc = 0; ifid = 0; fid = 1;
        end
      end
    end
    e.ctl = {pc, ifid, idex, exmem, memwb, fif, fid, fmw};
    e.tmo = (m_mode == 2);
    e.st  = 2'(m_mode);
`ifdef PIPELINE_CTRL_PERF_EN
    e.sc = m_stalls;
    e.fe = m_flushes;
`else
    e.sc = '0;
    e.fe = '0;
`endif
    exp_q.push_back(e);
    tags_q.push_back(tag);
    if (s.rst) begin
      if (!pc && m_mode != 2) m_stalls++;
      if (fif) m_flushes++;
      if (m_mode == 0 && hold) begin
        m_mode = 1; m_waits = 0;
      end else if (m_mode == 1) begin
        if (hold) begin
          m_waits++;
          if (m_waits == TMO) m_mode = 2;
        end else begin
          m_mode = 0;
        end
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, rs1: '0, rs2: '0, rd: '0, u1: 1'b0, u2: 1'b0,
          ld: 1'b0, br: 1'b0, req: 1'b0, ack: 1'b0};
    return s;
  endfunction

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
  initial begin
    obs_t a, e;
    int   t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tags_q.pop_front();
        a.ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};
        a.tmo = mem_timeout;
        a.st  = state;
`ifdef PIPELINE_CTRL_PERF_EN
        a.sc = stall_cycles;
        a.fe = flush_events;
`else
        a.sc = '0;
        a.fe = '0;
`endif
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs tag=%0d t=%0t got ctl=%b tmo=%b st=%0d sc=%0d fe=%0d expected ctl=%b tmo=%b st=%0d sc=%0d fe=%0d",
                   t, $time, a.ctl, a.tmo, a.st, a.sc, a.fe, e.ctl, e.tmo, e.st, e.sc, e.fe);
        end
      end
    end
  end

  initial begin
    stim_t s;
    bit    long_wait;
    // reset state
    tag = 1; s = idle(); s.rst = 0; step(s); step(s);
    s = idle(); step(s); step(s);
    // load-use on rs1 then on rs2, then same with x0
    tag = 2; s = idle(); s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; step(s);
    step(idle());
    s = idle(); s.ld = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; s.rs1 = 7; step(s);
    tag = 3; s = idle(); s.ld = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; step(s);
    s = idle(); s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 0; step(s);
    // memory wait acked after 3 cycles
    tag = 4; s = idle(); s.req = 1; step(s); step(s); step(s);
    s.ack = 1; step(s); step(idle());
    // branch frozen during wait, flushes on ack
    tag = 5; s = idle(); s.req = 1; s.br = 1; step(s); step(s);
    s.ack = 1; step(s); step(idle());
    // branch together with load-use
    tag = 6; s = idle(); s.br = 1; s.ld = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1; step(s);
    step(idle());
    // ack on the last allowed wait cycle
    tag = 7; s = idle(); s.req = 1;
    for (int i = 0; i < int'(TMO); i++) step(s);
    s.ack = 1; step(s); step(idle());
    // never acked: watchdog trips and holds
    tag = 8; s = idle(); s.req = 1; s.br = 1;
    for (int i = 0; i < int'(TMO) + 6; i++) step(s);
    s = idle(); s.rst = 0; step(s);
    step(idle());
    // reset mid-stall
    tag = 9; s = idle(); s.req = 1;
    for (int i = 0; i < 3; i++) step(s);
    s = idle(); s.rst = 0; step(s);
    step(idle());
    // random traffic
    tag = 10; long_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      s.rs1 = RW'($urandom_range(3)); s.rs2 = RW'($urandom_range(3));
      s.rd  = RW'($urandom_range(3));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.ld = 1'($urandom);
      s.br = ($urandom_range(3) == 0);
      if (m_mode == 1) begin
        s.req = 1; s.ack = long_wait ? 1'b0 : ($urandom_range(3) == 0);
      end else begin
        s.req = ($urandom_range(4) == 0); s.ack = 1'($urandom);
        long_wait = ($urandom_range(9) == 0);
      end
      s.rst = (m_mode == 2) ? ($urandom_range(7) != 0) : ($urandom_range(199) != 0);
      step(s);
    end
    step(idle());
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
